dual_issue_ctrl: RTL

// Issue controller for the dual-issue ID->REG boundary. Each cycle it receives two decoded

---
 rtl/dual_issue_ctrl.sv | 117 +++++++++++
 1 files changed

// File: rtl/dual_issue_ctrl.sv
// Dual-issue controller for the ID->REG boundary: per-register latency scoreboard plus
// a PAIR/SPLIT FSM that decides which of the two decoded slots enter ID/REG this cycle.
module dual_issue_ctrl #(
    parameter int NUM_REGS = 128,
    parameter int LAT_W    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id1_valid,
    input  logic             id1_pipe,
    input  logic [6:0]       id1_ra,
    input  logic [6:0]       id1_rb,
    input  logic [6:0]       id1_rc,
    input  logic [2:0]       id1_src_used,
    input  logic [6:0]       id1_rt,
    input  logic             id1_wr,
    input  logic [LAT_W-1:0] id1_lat,
    input  logic             id2_valid,
    input  logic             id2_pipe,
    input  logic [6:0]       id2_ra,
    input  logic [6:0]       id2_rb,
    input  logic [6:0]       id2_rc,
    input  logic [2:0]       id2_src_used,
    input  logic [6:0]       id2_rt,
    input  logic             id2_wr,
    input  logic [LAT_W-1:0] id2_lat,
    input  logic             flush,
    output logic             issue1,
    output logic             issue2,
    output logic             stall_id,
    output logic             split_pending
);

    typedef enum logic {PAIR, SPLIT} state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [LAT_W-1:0]        cnt [NUM_REGS];
    logic [NUM_REGS-1:0]     busy;
    logic                    raw1, raw2, waw1, waw2;
    logic                    dep12, same_rt;

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            busy[i] = (cnt[i] != '0);
        end
    end

    assign raw1 = (id1_src_used[0] & busy[id1_ra]) |
                  (id1_src_used[1] & busy[id1_rb]) |
                  (id1_src_used[2] & busy[id1_rc]);
    assign raw2 = (id2_src_used[0] & busy[id2_ra]) |
                  (id2_src_used[1] & busy[id2_rb]) |
                  (id2_src_used[2] & busy[id2_rc]);

    // A write whose result would land before an older in-flight write to rt must wait.
    assign waw1 = id1_wr & (cnt[id1_rt] > id1_lat);
    assign waw2 = id2_wr & (cnt[id2_rt] > id2_lat);

    assign dep12 = id1_wr & ((id2_src_used[0] & (id2_ra == id1_rt)) |
                             (id2_src_used[1] & (id2_rb == id1_rt)) |
                             (id2_src_used[2] & (id2_rc == id1_rt)));
    assign same_rt = id1_wr & id2_wr & (id1_rt == id2_rt);

    always_comb begin
        issue1    = 1'b0;
        issue2    = 1'b0;
        stall_id  = 1'b0;
        state_nxt = state;
        if (reset || flush) begin
            state_nxt = PAIR;
        end else if (state == PAIR) begin
            issue1 = id1_valid & ~raw1 & ~waw1;
            issue2 = issue1 & id2_valid & ~raw2 & ~waw2 & (id2_pipe != id1_pipe) &
                     ~dep12 & ~same_rt;
            if (id1_valid && !issue1) begin
                stall_id = 1'b1;
            end else if (issue1 && id2_valid && !issue2) begin
                stall_id  = 1'b1;
                state_nxt = SPLIT;
            end
        end else begin
            // Slot1 already went down the pipe; only slot2's own hazards matter now.
            issue2 = id2_valid & ~raw2 & ~waw2;
            if (id2_valid && !issue2) begin
                stall_id = 1'b1;
            end else begin
                state_nxt = PAIR;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt[i] <= '0;
            end
            state <= PAIR;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (cnt[i] != '0) begin
                    cnt[i] <= cnt[i] - LAT_W'(1);
                end
            end
            if (issue1 && id1_wr && id1_lat != '0) begin
                cnt[id1_rt] <= id1_lat;
            end
            if (issue2 && id2_wr && id2_lat != '0) begin
                cnt[id2_rt] <= id2_lat;
            end
            state <= state_nxt;
        end
    end

    assign split_pending = (state == SPLIT);

endmodule
